xbar_requester: RTL

Crossbar input-port requester that sits upstream of each output arbiter. It buffers incoming flits in a local FIFO and raises a one-hot `request` toward the destination output's arbiter. It holds that request until the arbiter's `grant` matches, then streams the whole packet to the crossbar and releases the request after the last flit. It is the grant-consuming side of the 4-way request/grant arbitration interface.

---
 rtl/xbar_requester_if.sv | 31 +++
 rtl/xbar_requester.sv | 113 +++++++++++
 2 files changed

// File: rtl/xbar_requester_if.sv
// Request/grant and flit streaming bundle between an input-port requester,
// its upstream flit source, the output arbiters and the crossbar.
interface xbar_requester_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_OUT = 4,
    parameter int DEST_W  = 2
);
    // A flit moves on a rising edge where both valid and ready are high; valid
    // never depends combinationally on the ready of the same channel.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [DEST_W-1:0] in_dest;
    logic [NUM_OUT-1:0] request;
    logic [NUM_OUT-1:0] grant;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  in_valid, in_data, in_last, in_dest, grant, out_ready,
        output in_ready, request, out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, in_last, in_dest, grant, out_ready,
        input  in_ready, request, out_valid, out_data, out_last
    );
endinterface

// File: rtl/xbar_requester.sv
// Crossbar input-port requester: buffers flits, requests the head packet's
// output, and streams the whole packet while the matching grant is held.
module xbar_requester #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int DEST_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    xbar_requester_if.master       bus,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [1:0]             fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DEST_W + 1 + DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] request_q, request_d;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               full, empty;
    logic               push, pop;
    logic [EW-1:0]      head;
    logic [DEST_W-1:0]  head_dest;
    logic               head_last;
    logic               granted;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (wr_ptr == rd_ptr);
    assign fill_level = count;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_dest  = head[EW-1 -: DEST_W];
    assign head_last  = head[DATA_W];

    assign granted    = |(bus.grant & request_q);

    assign bus.in_ready  = ~full;
    assign bus.request   = request_q;
    assign bus.out_valid = (state_q == XFER) & ~empty & granted;
    assign bus.out_data  = head[DATA_W-1:0];
    assign bus.out_last  = head_last;

    assign push = bus.in_valid & ~full;
    assign pop  = bus.out_valid & bus.out_ready;

    assign fsm_state = state_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_dest, bus.in_last, bus.in_data};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            request_q <= '0;
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
        end
    end

    // Returning to IDLE with request cleared guarantees one request-free
    // cycle between packets so the arbiter can rotate.
    always_comb begin
        state_d   = state_q;
        request_d = request_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    request_d = NUM_OUT'(1) << head_dest;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (granted) state_d = XFER;
            end
            XFER: begin
                if (pop && head_last) begin
                    request_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                request_d = '0;
            end
        endcase
    end
endmodule
